// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline slice: ALU status bit positions,
// exception cause codes, default widths and the EX/MEM fault decoder.
package mips_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int DEST_W_DEF = 5;
   localparam int STAT_W_DEF = 8;

   // ALU status bit indices
   localparam int STAT_ZERO     = 7;
   localparam int STAT_OVF      = 6;
   localparam int STAT_GROW     = 5;
   localparam int STAT_NEG      = 4;
   localparam int STAT_MISALIGN = 3;
   localparam int STAT_DIV0     = 2;

   typedef enum logic [4:0] {
      EXC_NONE = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_OV   = 5'd12,
      EXC_DIVZ = 5'd15
   } exc_code_e;

   // Priority: load misalign, store misalign, divide-by-zero, trapping overflow.
   function automatic logic [4:0] decode_fault(
      input logic misalign,
      input logic div0,
      input logic ovf,
      input logic mem_read,
      input logic mem_write,
      input logic trap_ovf
   );
      logic [4:0] code;
      code = EXC_NONE;
      if (misalign && mem_read)       code = EXC_ADEL;
      else if (misalign && mem_write) code = EXC_ADES;
      else if (div0)                  code = EXC_DIVZ;
      else if (ovf && trap_ovf)       code = EXC_OV;
      return code;
   endfunction

endpackage

// File: rtl/skid_buffer.sv
// Generic 2-entry valid/ready payload buffer with a registered in_ready.
// Ports: clk, rst_n (async active-low), flush (sync, drops both entries),
//        in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data
//        (downstream, out_data is the main register).
module skid_buffer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         main_valid_q, main_valid_d;
   logic [W-1:0] main_data_q,  main_data_d;
   logic         skid_valid_q, skid_valid_d;
   logic [W-1:0] skid_data_q,  skid_data_d;
   logic         in_ready_q,   in_ready_d;
   logic         in_xfer, out_xfer;

   assign in_xfer  = in_valid & in_ready_q;
   assign out_xfer = main_valid_q & out_ready;

   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (skid_valid_q) begin
         // in_ready is low while skid holds data, so no input can arrive here
         if (out_xfer) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
         end
      end else if (!main_valid_q || out_xfer) begin
         main_valid_d = in_xfer;
         if (in_xfer) main_data_d = in_data;
      end else if (in_xfer) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_data;
      end
      in_ready_d = ~skid_valid_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         in_ready_q   <= 1'b1;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary. Captures ALU result/status plus side-band control
// into a 2-entry skid buffer, decodes status into a precise exception code at
// capture, gates architectural side effects of faulting entries and keeps a
// sticky first-cause/EPC record for CP0.
// Ports: in_* (EX side, valid/ready), out_* (MEM side, valid/ready),
//        exc_valid/exc_code (fault of presented entry), sticky_* (first
//        committed fault), exc_clear, flush, clk, rst_n (async active-low).
module ex_mem_stage
   import mips_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEST_W = DEST_W_DEF,
   parameter int STAT_W = STAT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic [STAT_W-1:0] in_status,
   input  logic [DATA_W-1:0] in_rt_data,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [DEST_W-1:0] in_dest,
   input  logic              in_reg_write,
   input  logic              in_mem_read,
   input  logic              in_mem_write,
   input  logic              in_trap_ovf,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [DATA_W-1:0] out_rt_data,
   output logic [DATA_W-1:0] out_pc,
   output logic [DEST_W-1:0] out_dest,
   output logic              out_reg_write,
   output logic              out_mem_read,
   output logic              out_mem_write,
   output logic              out_zero,
   output logic              exc_valid,
   output logic [4:0]        exc_code,
   output logic              sticky_valid,
   output logic [4:0]        sticky_code,
   output logic [DATA_W-1:0] sticky_epc,
   input  logic              exc_clear
);

   localparam int PAY_W = 3*DATA_W + DEST_W + 4 + 5;

   logic [PAY_W-1:0] in_pay, out_pay;
   logic [4:0]       in_code, pay_code;
   logic             pay_reg_write, pay_mem_read, pay_mem_write, pay_fault;
   logic             out_xfer, capture;
   logic             status_unused;

   logic              sticky_valid_q, sticky_valid_d;
   logic [4:0]        sticky_code_q,  sticky_code_d;
   logic [DATA_W-1:0] sticky_epc_q,   sticky_epc_d;

   // grow/neg and the low status bits are informational only
   assign status_unused = ^in_status;

   assign in_code = decode_fault(in_status[STAT_MISALIGN], in_status[STAT_DIV0],
                                 in_status[STAT_OVF], in_mem_read, in_mem_write,
                                 in_trap_ovf);

   assign in_pay = {in_result, in_rt_data, in_pc, in_dest, in_reg_write,
                    in_mem_read, in_mem_write, in_status[STAT_ZERO], in_code};

   skid_buffer #(.W(PAY_W)) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_pay),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_pay)
   );

   assign {out_result, out_rt_data, out_pc, out_dest, pay_reg_write,
           pay_mem_read, pay_mem_write, out_zero, pay_code} = out_pay;

   assign pay_fault     = |pay_code;
   assign out_reg_write = pay_reg_write & ~pay_fault;
   assign out_mem_read  = pay_mem_read  & ~pay_fault;
   assign out_mem_write = pay_mem_write & ~pay_fault;
   assign exc_valid     = out_valid & pay_fault;
   assign exc_code      = out_valid ? pay_code : 5'd0;

   // Capture also fires against a same-cycle clear so the newer cause wins.
   assign out_xfer = out_valid & out_ready;
   assign capture  = out_xfer & pay_fault & (~sticky_valid_q | exc_clear);

   always_comb begin
      sticky_valid_d = sticky_valid_q;
      sticky_code_d  = sticky_code_q;
      sticky_epc_d   = sticky_epc_q;
      if (capture) begin
         sticky_valid_d = 1'b1;
         sticky_code_d  = pay_code;
         sticky_epc_d   = out_pc;
      end else if (exc_clear) begin
         sticky_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_valid_q <= 1'b0;
         sticky_code_q  <= 5'd0;
         sticky_epc_q   <= '0;
      end else begin
         sticky_valid_q <= sticky_valid_d;
         sticky_code_q  <= sticky_code_d;
         sticky_epc_q   <= sticky_epc_d;
      end
   end

   assign sticky_valid = sticky_valid_q;
   assign sticky_code  = sticky_code_q;
   assign sticky_epc   = sticky_epc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready;
   logic [31:0] in_result, in_rt_data, in_pc;
   logic [7:0]  in_status;
   logic [4:0]  in_dest;
   logic        in_reg_write, in_mem_read, in_mem_write, in_trap_ovf;
   logic        out_valid, out_ready;
   logic [31:0] out_result, out_rt_data, out_pc;
   logic [4:0]  out_dest;
   logic        out_reg_write, out_mem_read, out_mem_write, out_zero;
   logic        exc_valid;
   logic [4:0]  exc_code;
   logic        sticky_valid;
   logic [4:0]  sticky_code;
   logic [31:0] sticky_epc;
   logic        exc_clear;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   ex_mem_stage dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_status(in_status), .in_rt_data(in_rt_data),
      .in_pc(in_pc), .in_dest(in_dest), .in_reg_write(in_reg_write),
      .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_trap_ovf(in_trap_ovf),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_rt_data(out_rt_data), .out_pc(out_pc),
      .out_dest(out_dest), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
      .out_mem_write(out_mem_write), .out_zero(out_zero),
      .exc_valid(exc_valid), .exc_code(exc_code),
      .sticky_valid(sticky_valid), .sticky_code(sticky_code), .sticky_epc(sticky_epc),
      .exc_clear(exc_clear)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic v, input logic [31:0] res, input logic [7:0] st,
                      input logic [31:0] pc, input logic rw, input logic mr,
                      input logic mw, input logic trap);
      in_valid     = v;
      in_result    = res;
      in_status    = st;
      in_pc        = pc;
      in_rt_data   = res ^ 32'hAAAA_0000;
      in_dest      = res[4:0];
      in_reg_write = rw;
      in_mem_read  = mr;
      in_mem_write = mw;
      in_trap_ovf  = trap;
   endtask

   task automatic idle();
      drv(1'b0, 32'h0, 8'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; exc_clear = 1'b0;
      idle();
      #23;
      checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else passed++;
      checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else passed++;
      checks++; if (sticky_valid !== 1'b0 || exc_valid !== 1'b0) $display("FAIL reset_exc got %b%b exp 00", sticky_valid, exc_valid); else passed++;
      checks++; if (out_result !== 32'h0 || exc_code !== 5'd0 || sticky_epc !== 32'h0 || sticky_code !== 5'd0)
         $display("FAIL reset_data got %h %h %h %h exp zeros", out_result, exc_code, sticky_epc, sticky_code); else passed++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_stream();
      logic [31:0] exp_res [4];
      exp_res = '{32'h10, 32'h20, 32'h30, 32'h40};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drv(1'b1, exp_res[i], 8'h0, 32'h100 + 32'(i*4), 1'b1, 1'b0, 1'b0, 1'b0);
         tick();
         checks++; if (out_valid !== 1'b1 || out_result !== exp_res[i])
            $display("FAIL stream_out[%0d] got v=%b %h exp v=1 %h", i, out_valid, out_result, exp_res[i]); else passed++;
         checks++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d] got %b exp 1", i, in_ready); else passed++;
      end
      checks++; if (out_rt_data !== 32'hAAAA_0040 || out_dest !== 5'h0 || out_pc !== 32'h10C || out_reg_write !== 1'b1)
         $display("FAIL stream_sideband got %h %h %h %b exp aaaa0040 00 0000010c 1", out_rt_data, out_dest, out_pc, out_reg_write); else passed++;
      idle();
      tick();
      checks++; if (out_valid !== 1'b0) $display("FAIL stream_drain got %b exp 0", out_valid); else passed++;
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drv(1'b1, 32'h10, 8'h0, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (out_result !== 32'h10 || in_ready !== 1'b1) $display("FAIL bp_first got %h rdy=%b exp 10 rdy=1", out_result, in_ready); else passed++;
      drv(1'b1, 32'h20, 8'h0, 32'h204, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready_drop got %b exp 0", in_ready); else passed++;
      drv(1'b1, 32'h30, 8'h0, 32'h208, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (out_result !== 32'h10 || out_valid !== 1'b1 || in_ready !== 1'b0)
         $display("FAIL bp_stall got %h v=%b rdy=%b exp 10 v=1 rdy=0", out_result, out_valid, in_ready); else passed++;
      out_ready = 1'b1;
      tick();
      checks++; if (out_result !== 32'h20 || in_ready !== 1'b1) $display("FAIL bp_release got %h rdy=%b exp 20 rdy=1", out_result, in_ready); else passed++;
      tick();
      checks++; if (out_result !== 32'h30 || out_valid !== 1'b1) $display("FAIL bp_third got %h v=%b exp 30 v=1", out_result, out_valid); else passed++;
      idle();
      tick();
      checks++; if (out_valid !== 1'b0) $display("FAIL bp_drain got %b exp 0", out_valid); else passed++;
   endtask

   task automatic test_decode();
      // status, mem_read, mem_write, trap_ovf, reg_write, expected code, expected zero
      logic [7:0] st   [8] = '{8'h08, 8'h08, 8'h0C, 8'h44, 8'h40, 8'h40, 8'hB0, 8'h08};
      logic       mr   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic       mw   [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic       tr   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [4:0] code [8] = '{5'd4, 5'd5, 5'd4, 5'd15, 5'd12, 5'd0, 5'd0, 5'd0};
      logic       zr   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic       exp_f;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drv(1'b1, 32'h50 + 32'(i), st[i], 32'h700 + 32'(i*4), 1'b1, mr[i], mw[i], tr[i]);
         tick();
         exp_f = (code[i] != 5'd0);
         checks++; if (exc_code !== code[i] || exc_valid !== exp_f || out_zero !== zr[i])
            $display("FAIL decode_code[%0d] got code=%0d v=%b z=%b exp code=%0d v=%b z=%b",
                     i, exc_code, exc_valid, out_zero, code[i], exp_f, zr[i]); else passed++;
         checks++; if (out_reg_write !== ~exp_f || out_mem_read !== (mr[i] & ~exp_f) || out_mem_write !== (mw[i] & ~exp_f))
            $display("FAIL decode_gate[%0d] got rw=%b mr=%b mw=%b exp rw=%b mr=%b mw=%b",
                     i, out_reg_write, out_mem_read, out_mem_write, ~exp_f, mr[i] & ~exp_f, mw[i] & ~exp_f); else passed++;
      end
      idle();
      tick();
      checks++; if (sticky_valid !== 1'b1 || sticky_code !== 5'd4 || sticky_epc !== 32'h700)
         $display("FAIL decode_sticky got v=%b code=%0d epc=%h exp v=1 code=4 epc=00000700", sticky_valid, sticky_code, sticky_epc); else passed++;
      exc_clear = 1'b1;
      tick();
      exc_clear = 1'b0;
      checks++; if (sticky_valid !== 1'b0) $display("FAIL decode_clear got %b exp 0", sticky_valid); else passed++;
   endtask

   task automatic test_adel();
      out_ready = 1'b1;
      drv(1'b1, 32'h1234, 8'h08, 32'h400, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      checks++; if (exc_valid !== 1'b1 || exc_code !== 5'd4 || out_mem_read !== 1'b0)
         $display("FAIL adel_present got v=%b code=%0d mr=%b exp v=1 code=4 mr=0", exc_valid, exc_code, out_mem_read); else passed++;
      idle();
      tick();
      checks++; if (sticky_valid !== 1'b1 || sticky_code !== 5'd4 || sticky_epc !== 32'h400)
         $display("FAIL adel_sticky got v=%b code=%0d epc=%h exp v=1 code=4 epc=00000400", sticky_valid, sticky_code, sticky_epc); else passed++;
      exc_clear = 1'b1;
      tick();
      exc_clear = 1'b0;
   endtask

   task automatic test_ov_divz();
      out_ready = 1'b0;
      drv(1'b1, 32'h7FFF_FFFF, 8'h40, 32'h500, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      checks++; if (exc_code !== 5'd12 || out_reg_write !== 1'b0) $display("FAIL ov_present got code=%0d rw=%b exp code=12 rw=0", exc_code, out_reg_write); else passed++;
      drv(1'b1, 32'h0, 8'h04, 32'h504, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (exc_code !== 5'd12 || out_pc !== 32'h500) $display("FAIL ov_stable got code=%0d pc=%h exp code=12 pc=00000500", exc_code, out_pc); else passed++;
      idle();
      out_ready = 1'b1;
      out_ready = 1'b1;
      tick();
      checks++; if (sticky_code !== 5'd12 || sticky_epc !== 32'h500 || exc_code !== 5'd15)
         $display("FAIL ov_sticky got sc=%0d epc=%h code=%0d exp sc=12 epc=00000500 code=15", sticky_code, sticky_epc, exc_code); else passed++;
      exc_clear = 1'b1;
      tick();
      exc_clear = 1'b0;
      checks++; if (sticky_valid !== 1'b1 || sticky_code !== 5'd15 || sticky_epc !== 32'h504)
         $display("FAIL divz_clear_capture got v=%b sc=%0d epc=%h exp v=1 sc=15 epc=00000504", sticky_valid, sticky_code, sticky_epc); else passed++;
      drv(1'b1, 32'h99, 8'h08, 32'h600, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      tick();
      checks++; if (sticky_code !== 5'd15 || sticky_epc !== 32'h504)
         $display("FAIL sticky_hold got sc=%0d epc=%h exp sc=15 epc=00000504", sticky_code, sticky_epc); else passed++;
      exc_clear = 1'b1;
      tick();
      exc_clear = 1'b0;
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drv(1'b1, 32'h11, 8'h0, 32'h900, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drv(1'b1, 32'h22, 8'h0, 32'h904, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (in_ready !== 1'b0) $display("FAIL flush_setup got rdy=%b exp 0", in_ready); else passed++;
      drv(1'b1, 32'h33, 8'h0, 32'h908, 1'b1, 1'b0, 1'b0, 1'b0);
      flush = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL flush_full got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); else passed++;
      drv(1'b1, 32'h44, 8'h0, 32'h90C, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      flush = 1'b0;
      checks++; if (out_valid !== 1'b0) $display("FAIL flush_drop_input got v=%b exp 0", out_valid); else passed++;
      out_ready = 1'b1;
      drv(1'b1, 32'h55, 8'h0, 32'h910, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (out_valid !== 1'b1 || out_result !== 32'h55) $display("FAIL flush_after got v=%b %h exp v=1 00000055", out_valid, out_result); else passed++;
      idle();
      tick();
      checks++; if (out_valid !== 1'b0) $display("FAIL flush_no_ghost got v=%b exp 0", out_valid); else passed++;
      out_ready = 1'b0;
      drv(1'b1, 32'h66, 8'h04, 32'h800, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      out_ready = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (out_valid !== 1'b0 || sticky_valid !== 1'b1 || sticky_code !== 5'd15 || sticky_epc !== 32'h800)
         $display("FAIL flush_sticky got v=%b sv=%b sc=%0d epc=%h exp v=0 sv=1 sc=15 epc=00000800",
                  out_valid, sticky_valid, sticky_code, sticky_epc); else passed++;
   endtask

   task automatic test_reset_mid_stall();
      out_ready = 1'b0;
      drv(1'b1, 32'h77, 8'h0, 32'hA00, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drv(1'b1, 32'h88, 8'h0, 32'hA04, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'h0 || out_pc !== 32'h0)
         $display("FAIL rst_mid_buf got v=%b rdy=%b %h %h exp v=0 rdy=1 zeros", out_valid, in_ready, out_result, out_pc); else passed++;
      checks++; if (sticky_valid !== 1'b0 || sticky_epc !== 32'h0 || exc_valid !== 1'b0)
         $display("FAIL rst_mid_exc got sv=%b epc=%h ev=%b exp 0", sticky_valid, sticky_epc, exc_valid); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0) $display("FAIL rst_mid_empty got v=%b exp 0", out_valid); else passed++;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_decode();
      test_adel();
      test_ov_divz();
      test_flush();
      test_reset_mid_stall();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Sits directly downstream of the ALU and forms the EX/MEM boundary of the MIPS pipeline.
- Registers the ALU result and 8-bit ALU status together with the instruction's side-band control, then hands them to the memory stage over a valid/ready handshake.
- Uses a 2-entry skid buffer so that `in_ready` is registered.
- Decodes the ALU status flags into precise exceptions and suppresses architectural side effects for faulting instructions.
- Keeps a sticky cause/EPC record for the CP0 logic.

Parameters:
- DATA_W, 32, width of result, store data, PC
- DEST_W, 5, register-file index width
- STAT_W, 8, ALU status width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill all buffered entries (branch/exception redirect)
- in_valid  in  1  EX stage offers an entry
- in_ready  out  1  stage can accept (registered)
- in_result  in  DATA_W  ALU_result
- in_status  in  STAT_W  ALU_status: [7]zero [6]ovf [5]width-grow [4]neg [3]misalign [2]div0
- in_rt_data  in  DATA_W  store data
- in_pc  in  DATA_W  instruction PC
- in_dest  in  DEST_W  destination register
- in_reg_write, in_mem_read, in_mem_write, in_trap_ovf  in  1 each  control bits; trap_ovf=1 for add/sub/addi
- out_valid  out  1  entry presented to MEM
- out_ready  in  1  MEM accepts
- out_result, out_rt_data, out_pc  out  DATA_W  registered copies
- out_dest  out  DEST_W
- out_reg_write, out_mem_read, out_mem_write  out  1  gated to 0 when entry faults
- out_zero  out  1  in_status[7] copy
- exc_valid  out  1  current out entry faults (= out_valid & fault)
- exc_code  out  5  cause of current out entry
- sticky_valid  out  1  an exception has been committed since last clear
- sticky_code  out  5  first committed cause
- sticky_epc  out  DATA_W  PC of that instruction
- exc_clear  in  1  clear sticky record

Behaviour:
- Reset (async, rst_n=0):
  - out_valid, exc_valid and sticky_valid are 0.
  - in_ready is 1.
  - All data outputs, exc_code, sticky_code and sticky_epc are 0.
  - Both buffer slots are empty.
- Handshake:
  - An input transfer occurs when in_valid&in_ready.
  - An output transfer occurs when out_valid&out_ready.
  - Data must stay stable while out_valid&~out_ready.
- Buffer:
  - Main register (presented) plus skid register.
  - in_ready = ~skid_full, registered.
  - Latency is 1 cycle from input transfer to out_valid when main is empty or draining.
  - Input while main is full and not draining → the entry goes to skid; in_ready drops the next cycle.
  - On drain, skid moves to main; in_ready rises the following cycle.
  - Simultaneous input transfer and output transfer with skid empty → main reloads directly, no bubble.
  - Order is strictly FIFO.
- Fault decode at input capture (priority high→low):
  - status[3] & in_mem_read → 4 (AdEL)
  - status[3] & in_mem_write → 5 (AdES)
  - status[2] → 15 (DivZ, team code)
  - status[6] & in_trap_ovf → 12 (Ov)
  - otherwise no fault, code 0.
  - Status bits [5], [4] and [7] never fault.
- A faulting entry still travels and handshakes normally. Its out_reg_write, out_mem_read and out_mem_write are forced to 0. exc_valid and exc_code are stable with the entry.
- Sticky capture:
  - On an output transfer of a faulting entry while sticky_valid=0, latch code and PC and set sticky_valid.
  - Later faults do not overwrite.
  - exc_clear clears sticky_valid. If exc_clear and a capturing transfer happen in the same cycle, the new capture wins.
- Flush:
  - Synchronous; highest priority.
  - Next cycle both slots are empty, out_valid=0 and in_ready=1.
  - An input offered in the flush cycle is dropped.
  - An output transfer in the flush cycle still counts for sticky capture.
  - Sticky state is not touched by flush.
- Reset mid-stall discards all entries immediately.

Decomposition:
- Shared package `mips_pkg`:
  - STAT_* bit indices for ALU status
  - EXC_ADEL=4, EXC_ADES=5, EXC_OV=12, EXC_DIVZ=15
  - DATA_W and DEST_W defaults
- One natural sub-module `skid_buffer` (generic 2-entry valid/ready payload buffer). The top level handles fault decode, gating and the sticky record.

Test Plan:
- Stream of 4 entries with out_ready=1, result=0x10,0x20,0x30,0x40 → same values at out, 1-cycle latency, in_ready stays 1.
- out_ready=0 for 3 cycles while 3 entries are offered → 2 accepted, in_ready=0 from the cycle after the 2nd acceptance. Release → order 0x10, 0x20, then 3rd accepted.
- Load with status=0x08, pc=0x400 → exc_valid=1, exc_code=4, out_mem_read=0. After transfer: sticky_code=4, sticky_epc=0x400.
- Add with status=0x40 and trap_ovf=1, followed by a div with status=0x04 → codes 12 then 15. The sticky record keeps 12. exc_clear together with the second transfer → sticky_code=15.
- Status=0x40 with trap_ovf=0 (addu) → no fault, reg_write passes through.
- Flush with 2 entries buffered and in_valid=1 → next cycle out_valid=0, in_ready=1, dropped entries never appear. Assert rst_n low mid-stall → all outputs 0 asynchronously.
